// File: rtl/fwht_engine.sv
// Iterative fast Walsh-Hadamard transform, one butterfly stage per clock.
// Optional FWHT_ROUND_EN: inverse mode rounds half-up instead of flooring.
module fwht_engine #(
    parameter int M    = 8,
    parameter int N    = 16,
    parameter int logN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic                      inv,
    input  logic [M*N-1:0]            u,
    output logic                      ready,
    output logic                      done,
    output logic [N*(M+logN)-1:0]     y
);

    localparam int W = M + logN;
    localparam logic [logN-1:0] S_LAST = logN'(logN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    state_t state, state_nx;

    logic [logN-1:0]      s;
    logic                 inv_q;
    logic signed [W-1:0]  w  [N];
    logic signed [W-1:0]  wn [N];
    logic [N*W-1:0]       y_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (valid) state_nx = RUN;
            RUN:     if (s == S_LAST) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

    // Each element pairs with the partner differing only in bit s.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            logic [logN-1:0] ii, pp;
            ii = logN'(i);
            pp = ii ^ (logN'(1) << s);
            if (ii[s]) wn[ii] = w[pp] - w[ii];
            else       wn[ii] = w[ii] + w[pp];
        end
    end

    always_comb begin
        y_nx = '0;
        for (int i = 0; i < N; i++) begin
            logic signed [W:0] t;
            t = {w[i][W-1], w[i]};
`ifdef FWHT_ROUND_EN
            t = t + (W+1)'(1 << (logN - 1));
`endif
            if (inv_q) y_nx[i*W +: W] = W'(t >>> logN);
            else       y_nx[i*W +: W] = w[i];
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && valid) begin
            for (int i = 0; i < N; i++)
                w[i] <= {{logN{u[i*M+M-1]}}, u[i*M +: M]};
            s     <= '0;
            inv_q <= inv;
        end else if (state == RUN) begin
            for (int i = 0; i < N; i++)
                w[i] <= wn[i];
            s <= s + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y    <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == OUT);
            if (state == OUT) y <= y_nx;
        end
    end

endmodule

// File: tb/tb_fwht_engine.sv
// Self-checking bench for fwht_engine (N=16, M=8): vector table,
// handshake corner cases and random vectors against a direct H_N model.
module tb_fwht_engine;

    localparam int M  = 8;
    localparam int N  = 16;
    localparam int L  = 4;
    localparam int W  = M + L;
    localparam int UB = M * N;
    localparam int YB = N * W;

    logic          clk = 0;
    logic          rst = 1;
    logic          valid = 0;
    logic          inv = 0;
    logic [UB-1:0] u = '0;
    logic          ready, done;
    logic [YB-1:0] y;

    int n_cmp = 0;
    int n_bad = 0;

    fwht_engine #(.M(M), .N(N), .logN(L)) dut (
        .clk(clk), .rst(rst), .valid(valid), .inv(inv),
        .u(u), .ready(ready), .done(done), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [UB-1:0] u;
        logic          inv;
        logic [YB-1:0] y;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [YB-1:0] act,
                       input logic [YB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [UB-1:0] rep_u(input int v);
        logic [UB-1:0] r;
        for (int i = 0; i < N; i++) r[i*M +: M] = M'(v);
        return r;
    endfunction

    function automatic logic [UB-1:0] one_u(input int k, input int v);
        logic [UB-1:0] r;
        r = '0;
        r[k*M +: M] = M'(v);
        return r;
    endfunction

    function automatic logic [YB-1:0] rep_y(input int v);
        logic [YB-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [YB-1:0] one_y(input int k, input int v);
        logic [YB-1:0] r;
        r = '0;
        r[k*W +: W] = W'(v);
        return r;
    endfunction

    // y[k] = sum_i (-1)^popcount(k&i) * u[i], optionally divided by N
    function automatic logic [YB-1:0] model(input logic [UB-1:0] uv,
                                            input logic iv);
        logic [YB-1:0] r;
        for (int k = 0; k < N; k++) begin
            int acc;
            acc = 0;
            for (int i = 0; i < N; i++) begin
                int e;
                e = int'($signed(uv[i*M +: M]));
                if ($countones(k & i) % 2 == 1) acc -= e;
                else                            acc += e;
            end
            if (iv) begin
`ifdef FWHT_ROUND_EN
                acc = (acc + N / 2) >>> L;
`else
                acc = acc >>> L;
`endif
            end
            r[k*W +: W] = W'(acc);
        end
        return r;
    endfunction

    task automatic run(input logic [UB-1:0] uv, input logic iv,
                       output logic [YB-1:0] yv, output int lat,
                       output int dn);
        @(negedge clk);
        u = uv;
        inv = iv;
        valid = 1;
        @(posedge clk);
        #1;
        valid = 0;
        lat = 0;
        dn = 0;
        while (!ready && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) dn++;
        end
        yv = y;
        @(posedge clk);
        #1;
        if (done) dn++;
    endtask

    initial begin
        logic [YB-1:0] yv;
        logic [UB-1:0] ua, ub, pm;
        int lat, dn;

        for (int i = 0; i < N; i++)
            pm[i*M +: M] = ($countones(i) % 2 == 1) ? M'(-127) : M'(127);

        tv.push_back('{"all_ones",  rep_u(1),     1'b0, one_y(0, 16)});
        tv.push_back('{"impulse5",  one_u(0, 5),  1'b0, rep_y(5)});
        tv.push_back('{"impulse_m3", one_u(0, -3), 1'b0, rep_y(-3)});
        tv.push_back('{"all_min",   rep_u(-128),  1'b0, one_y(0, -2048)});
        tv.push_back('{"walsh15",   pm,           1'b0, one_y(15, 2032)});
`ifdef FWHT_ROUND_EN
        tv.push_back('{"inv_imp8",  one_u(0, 8),  1'b1, rep_y(1)});
`else
        tv.push_back('{"inv_imp8",  one_u(0, 8),  1'b1, rep_y(0)});
`endif
        tv.push_back('{"inv_ones",  rep_u(1),     1'b1, one_y(0, 1)});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", YB'(ready), YB'(1));
        chk("rst_done", YB'(done), YB'(0));
        chk("rst_y", y, '0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        chk("idle_ready", YB'(ready), YB'(1));

        foreach (tv[t]) begin
            run(tv[t].u, tv[t].inv, yv, lat, dn);
            chk({tv[t].name, "_y"}, yv, tv[t].y);
            chk({tv[t].name, "_lat"}, YB'(lat), YB'(5));
            chk({tv[t].name, "_done"}, YB'(dn), YB'(1));
        end

        // valid pulsed mid-transform must be ignored
        ua = one_u(3, 7);
        ub = rep_u(9);
        @(negedge clk);
        u = ua;
        inv = 0;
        valid = 1;
        @(negedge clk);
        u = ub;
        inv = 1;
        @(negedge clk);
        valid = 0;
        chk("busy_ready", YB'(ready), YB'(0));
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("busy_done", YB'(dn), YB'(1));
        chk("busy_y", y, model(ua, 1'b0));

        // reset in the middle of stage 2
        @(negedge clk);
        u = rep_u(3);
        inv = 0;
        valid = 1;
        @(posedge clk);
        #1;
        valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("mid_rst_ready", YB'(ready), YB'(1));
        chk("mid_rst_y", y, '0);
        chk("mid_rst_done", YB'(done), YB'(0));
        @(negedge clk);
        rst = 0;
        ua = one_u(5, -100);
        run(ua, 1'b0, yv, lat, dn);
        chk("post_rst_y", yv, model(ua, 1'b0));
        chk("post_rst_lat", YB'(lat), YB'(5));

        for (int r = 0; r < 100; r++) begin
            logic iv;
            ua = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom_range(0, 1));
            run(ua, iv, yv, lat, dn);
            chk($sformatf("rand%0d_y", r), yv, model(ua, iv));
            chk($sformatf("rand%0d_done", r), YB'(dn), YB'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
